// File: rtl/cordic_if.sv
// Sample bus of the CORDIC pipeline: an angle and tag go in, cos/sin and the same tag come out.
// A sample exists while its valid bit is 1. There is no ready: the consumer takes every out_valid.
interface cordic_if #(
  parameter int WIDTH = 23,
  parameter int TAG_W = 4
);
  logic                    in_valid;
  logic signed [WIDTH-1:0] in_theta;
  logic        [TAG_W-1:0] in_tag;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_cos;
  logic signed [WIDTH-1:0] out_sin;
  logic        [TAG_W-1:0] out_tag;
  logic                    out_range_err;

  modport master (
    output in_valid, in_theta, in_tag,
    input  out_valid, out_cos, out_sin, out_tag, out_range_err
  );

  modport slave (
    input  in_valid, in_theta, in_tag,
    output out_valid, out_cos, out_sin, out_tag, out_range_err
  );
endinterface

// File: rtl/cordic_pipe.sv
// Fully unrolled rotation-mode CORDIC: one angle in and one (cos, sin) pair out per enabled clock.
// Input register, ITERATIONS micro-rotation stages and a rounding output register.
module cordic_pipe #(
  parameter int FRACS      = 21,
  parameter int INTS       = 1,
  parameter int WIDTH      = INTS + FRACS + 1,
  parameter int ITERATIONS = 15,
  parameter int GUARD      = 2,
  parameter int TAG_W      = 4
) (
  input logic     clk,
  input logic     reset,
  input logic     clk_en,
  cordic_if.slave bus
);

  localparam int IW = WIDTH + GUARD;
  localparam int FB = FRACS + GUARD;
  localparam logic [63:0] ONE = 64'd1 << 60;

  // atan(1/n) in Q0.60 by its alternating power series; needs n >= 2 to converge.
  function automatic logic [63:0] atan_recip(input logic [63:0] n);
    logic [63:0] term;
    logic [63:0] pos;
    logic [63:0] neg;
    term = ONE / n;
    pos  = '0;
    neg  = '0;
    for (int k = 0; k < 64; k++) begin
      if (k % 2 == 0) pos = pos + term / 64'(2 * k + 1);
      else            neg = neg + term / 64'(2 * k + 1);
      term = term / (n * n);
    end
    return pos - neg;
  endfunction

  // atan(2^-i) in Q0.60; i = 0 (pi/4) goes through Machin's formula.
  function automatic logic [63:0] atan_pow2(input int i);
    if (i == 0) return (atan_recip(64'd5) << 2) - atan_recip(64'd239);
    return atan_recip(64'd1 << i);
  endfunction

  function automatic logic [63:0] scale_round(input logic [63:0] v, input int fb);
    return (v + (64'd1 << (59 - fb))) >> (60 - fb);
  endfunction

  localparam logic [63:0]        HALF_PI_64 = scale_round(atan_pow2(0) << 1, FRACS);
  localparam logic signed [WIDTH:0] HALF_PI = HALF_PI_64[WIDTH:0];
  localparam real                K_GAIN     = 0.6072529350088813;
  localparam int                 X0_INT     = $rtoi(K_GAIN * (2.0 ** FB) + 0.5);
  localparam logic signed [IW-1:0] X0       = IW'(X0_INT);
  localparam logic signed [IW:0] RND        = (IW + 1)'(2 ** (GUARD - 1));

  // Stage s holds the sample after s micro-rotations; stage 0 is the input register.
  logic signed [IW-1:0]   x_q   [0:ITERATIONS];
  logic signed [IW-1:0]   y_q   [0:ITERATIONS];
  logic signed [IW-1:0]   z_q   [0:ITERATIONS];
  logic                   v_q   [0:ITERATIONS];
  logic        [TAG_W-1:0] tag_q [0:ITERATIONS];
  logic                   err_q [0:ITERATIONS];

  logic signed [IW-1:0] x_n [0:ITERATIONS-1];
  logic signed [IW-1:0] y_n [0:ITERATIONS-1];
  logic signed [IW-1:0] z_n [0:ITERATIONS-1];

  logic signed [WIDTH:0]  theta_ext;
  logic signed [IW-1:0]   z_in;
  logic                   range_err;

  assign theta_ext = {bus.in_theta[WIDTH-1], bus.in_theta};
  assign z_in      = {bus.in_theta, {GUARD{1'b0}}};
  assign range_err = (theta_ext > HALF_PI) || (theta_ext < -HALF_PI);

  for (genvar i = 0; i < ITERATIONS; i++) begin : g_rot
    localparam logic [63:0]          A64    = scale_round(atan_pow2(i), FB);
    localparam logic signed [IW-1:0] ATAN_I = A64[IW-1:0];
    logic                 d;
    logic signed [IW-1:0] xs;
    logic signed [IW-1:0] ys;
    assign d      = z_q[i][IW-1];
    assign xs     = x_q[i] >>> i;
    assign ys     = y_q[i] >>> i;
    assign x_n[i] = d ? x_q[i] + ys : x_q[i] - ys;
    assign y_n[i] = d ? y_q[i] - xs : y_q[i] + xs;
    assign z_n[i] = d ? z_q[i] + ATAN_I : z_q[i] - ATAN_I;
  end

  logic signed [IW:0]       x_rnd;
  logic signed [IW:0]       y_rnd;
  logic                     out_valid_q;
  logic signed [WIDTH-1:0]  out_cos_q;
  logic signed [WIDTH-1:0]  out_sin_q;
  logic        [TAG_W-1:0]  out_tag_q;
  logic                     out_err_q;

  // Round half-up before dropping the guard bits; one extra bit keeps the add from wrapping.
  assign x_rnd = {x_q[ITERATIONS][IW-1], x_q[ITERATIONS]} + RND;
  assign y_rnd = {y_q[ITERATIONS][IW-1], y_q[ITERATIONS]} + RND;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s <= ITERATIONS; s++) v_q[s] <= 1'b0;
      out_valid_q <= 1'b0;
      out_cos_q   <= '0;
      out_sin_q   <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
    end else if (clk_en) begin
      v_q[0]   <= bus.in_valid;
      tag_q[0] <= bus.in_tag;
      err_q[0] <= range_err;
      x_q[0]   <= X0;
      y_q[0]   <= '0;
      z_q[0]   <= z_in;
      for (int s = 0; s < ITERATIONS; s++) begin
        x_q[s+1]   <= x_n[s];
        y_q[s+1]   <= y_n[s];
        z_q[s+1]   <= z_n[s];
        v_q[s+1]   <= v_q[s];
        tag_q[s+1] <= tag_q[s];
        err_q[s+1] <= err_q[s];
      end
      // Data fields follow the last stage even in bubbles; consumers qualify on out_valid.
      out_valid_q <= v_q[ITERATIONS];
      out_cos_q   <= x_rnd[IW-1:GUARD];
      out_sin_q   <= y_rnd[IW-1:GUARD];
      out_tag_q   <= tag_q[ITERATIONS];
      out_err_q   <= err_q[ITERATIONS];
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_cos       = out_cos_q;
  assign bus.out_sin       = out_sin_q;
  assign bus.out_tag       = out_tag_q;
  assign bus.out_range_err = out_err_q;

endmodule

// File: tb/tb_cordic_pipe.sv
// Bench for cordic_pipe: directed vector table, random stream, stall, bubbles and reset sequences.
module tb_cordic_pipe;

  localparam int LAT     = 17;
  localparam int TOL     = 128;
  localparam int HALF_PI = 3294199;
  localparam real SCALE  = 2097152.0;

  logic clk = 1'b0;
  logic reset;
  logic clk_en;

  always #5 clk = ~clk;

  cordic_if #(.WIDTH(23), .TAG_W(4)) bus ();

  cordic_pipe dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (bus.slave)
  );

  typedef struct packed {
    logic [3:0]         tag;
    logic               err;
    logic signed [31:0] c;
    logic signed [31:0] s;
    logic [31:0]        due;
  } exp_t;

  typedef struct {
    int         theta;
    logic [3:0] tag;
    logic       err;
    int         c;
    int         s;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[10];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   edge_idx = 0;
  logic last_en  = 1'b0;
  logic cur_err;
  int   cur_c;
  int   cur_s;

  task automatic check(input string name, input longint act, input longint req, input longint tol);
    n_checks++;
    if ((act - req <= tol) && (req - act <= tol)) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, req, tol);
  endtask

  function automatic int model(input int th, input bit want_sin);
    real r;
    r = real'(th) / SCALE;
    return want_sin ? int'($sin(r) * SCALE) : int'($cos(r) * SCALE);
  endfunction

  task automatic send(input logic v, input int th, input logic [3:0] tg,
                      input logic err, input int c, input int s);
    @(negedge clk);
    clk_en       = 1'b1;
    bus.in_valid = v;
    bus.in_theta = 23'(th);
    bus.in_tag   = tg;
    cur_err      = err;
    cur_c        = c;
    cur_s        = s;
  endtask

  task automatic send_model(input int th, input logic [3:0] tg);
    send(1'b1, th, tg, 1'b0, model(th, 1'b0), model(th, 1'b1));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < LAT + 10) begin
      send(1'b0, 0, 4'h0, 1'b0, 0, 0);
      k++;
    end
    check("drain_empty", exp_q.size(), 0, 0);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_valid"}, bus.out_valid, 0, 0);
    check({name, "_cos"},   bus.out_cos, 0, 0);
    check({name, "_sin"},   bus.out_sin, 0, 0);
    check({name, "_tag"},   bus.out_tag, 0, 0);
    check({name, "_err"},   bus.out_range_err, 0, 0);
  endtask

  // Record each sample the DUT accepts, with the enabled-edge index its result is due on.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      last_en <= 1'b0;
    end else if (clk_en) begin
      if (bus.in_valid)
        exp_q.push_back('{tag: bus.in_tag, err: cur_err, c: cur_c, s: cur_s, due: edge_idx + LAT});
      edge_idx <= edge_idx + 1;
      last_en  <= 1'b1;
    end else begin
      last_en <= 1'b0;
    end
  end

  // Scoreboard: compare on the half cycle after each enabled edge.
  always @(negedge clk) begin
    if (last_en) begin
      if (bus.out_valid) begin
        check("valid_expected", exp_q.size() > 0, 1, 0);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("latency", edge_idx, e.due, 0);
          check("tag", bus.out_tag, e.tag, 0);
          check("range_err", bus.out_range_err, e.err, 0);
          if (!e.err) begin
            check("cos", bus.out_cos, e.c, TOL);
            check("sin", bus.out_sin, e.s, TOL);
          end
        end
      end else if (exp_q.size() > 0) begin
        check("missing_output", exp_q[0].due <= edge_idx, 0, 0);
        if (exp_q[0].due <= edge_idx) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic               snap_valid;
    logic signed [22:0] snap_cos;
    logic [3:0]         snap_tag;
    int                 th;

    vecs[0] = '{0,        4'd3,  1'b0, 2097152,  0};
    vecs[1] = '{1647099,  4'd4,  1'b0, 1482910,  1482910};
    vecs[2] = '{-3294199, 4'd5,  1'b0, 0,        -2097152};
    vecs[3] = '{3294199,  4'd6,  1'b0, 0,        2097152};
    vecs[4] = '{1098066,  4'd7,  1'b0, 1816187,  1048576};
    vecs[5] = '{-2097152, 4'd8,  1'b0, 1133096,  -1764693};
    vecs[6] = '{3774874,  4'd9,  1'b1, 0,        0};
    vecs[7] = '{-4194304, 4'd10, 1'b1, 0,        0};
    vecs[8] = '{3294200,  4'd11, 1'b1, 0,        0};
    vecs[9] = '{-1647099, 4'd12, 1'b0, 1482910,  -1482910};

    // Reset while disabled must still clear everything.
    reset        = 1'b1;
    clk_en       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_theta = '0;
    bus.in_tag   = '0;
    cur_err = 1'b0; cur_c = 0; cur_s = 0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset_state");
    reset = 1'b0;

    // Directed table, back to back, then drained.
    for (int i = 0; i < 10; i++)
      send(1'b1, vecs[i].theta, vecs[i].tag, vecs[i].err, vecs[i].c, vecs[i].s);
    drain();

    // 200 random in-range angles, one per cycle, incrementing tags.
    for (int i = 0; i < 200; i++) begin
      th = int'($urandom_range(2 * HALF_PI)) - HALF_PI;
      send_model(th, 4'(i));
    end
    drain();

    // Random bubbles with a five-cycle stall in the middle.
    for (int i = 0; i < 60; i++) begin
      if (i == 30) begin
        @(negedge clk);
        clk_en       = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_theta = '0;
        bus.in_tag   = 4'hF;
        snap_valid   = bus.out_valid;
        snap_cos     = bus.out_cos;
        snap_tag     = bus.out_tag;
        repeat (5) begin
          @(negedge clk);
          check("stall_valid", bus.out_valid, snap_valid, 0);
          check("stall_cos", bus.out_cos, snap_cos, 0);
          check("stall_tag", bus.out_tag, snap_tag, 0);
        end
      end
      th = int'($urandom_range(2 * HALF_PI)) - HALF_PI;
      if ($urandom_range(1) == 1) send_model(th, 4'(i));
      else send(1'b0, th, 4'(i), 1'b0, 0, 0);
    end
    drain();

    // Reset with ten samples in flight; a sample alongside reset is dropped too.
    for (int i = 0; i < 10; i++) send_model(100000 * i, 4'(i));
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_tag   = 4'hE;
    @(negedge clk);
    check_zero_outputs("after_reset");
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    repeat (20) send(1'b0, 0, 4'h0, 1'b0, 0, 0);
    send_model(0, 4'hA);
    drain();

    // Reset while clk_en is low.
    for (int i = 0; i < 5; i++) send_model(-200000 * i, 4'(i + 3));
    @(negedge clk);
    reset        = 1'b1;
    clk_en       = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check_zero_outputs("reset_disabled");
    reset = 1'b0;
    repeat (20) send(1'b0, 0, 4'h0, 1'b0, 0, 0);
    send_model(1647099, 4'h5);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cordic_pipe.md
Name: cordic_pipe

Overview:
Fully unrolled, pipelined rotation-mode CORDIC that returns both cosine and sine of a signed fixed-point angle.
It accepts one angle per enabled clock and produces one result per enabled clock after a fixed latency.
A valid/tag sideband travels with each sample so upstream logic can interleave several channels.
It replaces the single-output cosine core in the trig datapath and feeds the downstream fixed-point consumers directly.

Parameters:
FRACS, 21, fractional bits of the angle and of the results.
INTS, 1, integer bits excluding sign.
WIDTH, INTS+FRACS+1, signed two's-complement width of angle and results.
ITERATIONS, 15, CORDIC micro-rotations. Legal range 4..FRACS.
GUARD, 2, extra LSBs carried internally on x, y and z.
TAG_W, 4, width of the user tag passed through unchanged.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high.
clk_en  in  1  global enable; when low the whole pipeline holds.
in_valid  in  1  angle/tag present this cycle.
in_theta  in  WIDTH  signed angle in radians, Q(INTS).(FRACS).
in_tag  in  TAG_W  user tag.
out_valid  out  1  result present.
out_cos  out  WIDTH  signed cos(theta), Q(INTS).(FRACS).
out_sin  out  WIDTH  signed sin(theta), Q(INTS).(FRACS).
out_tag  out  TAG_W  tag of the same sample.
out_range_err  out  1  the sample's |theta| exceeded pi/2; its cos/sin are unspecified.

Behaviour:
- Reset:
  - Synchronous, active-high; takes priority over clk_en.
  - On the next edge all stage valid bits and all outputs become 0 (out_valid=0, out_cos=0, out_sin=0, out_tag=0, out_range_err=0).
  - In-flight samples are discarded.
- clk_en=0: every register holds, including outputs. No sample is lost or duplicated. in_valid is ignored that cycle.
- Stage 0 (input register), on enabled edge:
  - x0 = round(K*2^(FRACS+GUARD)), where K = 0.6072529350088813.
  - y0 = 0.
  - z0 = theta sign-extended, shifted left by GUARD.
  - valid, tag and range_err (|theta| > round(pi/2*2^FRACS)) are captured.
- Stage i+1, for i = 0..ITERATIONS-1; d = sign of z_i (1 = negative):
  - x = d ? x + (y>>>i) : x - (y>>>i)
  - y = d ? y - (x>>>i) : y + (x>>>i)
  - z = d ? z + atan_i : z - atan_i
  - Shifts are arithmetic. Internal width is WIDTH+GUARD. No overflow is possible for |theta| <= pi/2 with INTS>=1.
- atan table: atan_i = round(atan(2^-i)*2^(FRACS+GUARD)), generated at elaboration for any ITERATIONS. No hand-coded constant list.
- Output register:
  - out_cos and out_sin are x and y of the last stage, rounded half-up: add 2^(GUARD-1), then drop GUARD LSBs.
  - out_tag, out_range_err and out_valid come from the same stage.
  - Outputs update only on enabled edges. Data fields still update when valid=0; consumers qualify on out_valid.
- Latency: exactly ITERATIONS+2 enabled edges from the edge sampling in_valid=1 to out_valid=1. Default is 17.
- Throughput: 1 sample per enabled cycle. There is no backpressure port; the consumer must accept every out_valid.
- Ordering: strictly FIFO. Tags never reorder.
- Bubbles: in_valid=0 propagates as an out_valid=0 slot at the same latency.
- Accuracy: |error| <= 2^(FRACS-ITERATIONS+1) LSB for |theta| <= pi/2. This is 128 LSB at the defaults.
- Boundaries:
  - theta = +pi/2 and -pi/2 are in range (range_err=0).
  - theta = -2^(WIDTH-1) gives range_err=1, and nothing else in the pipeline is corrupted.
  - reset asserted together with in_valid: the sample is dropped.
  - reset with clk_en=0: reset still applies.

Test Plan:
- Defaults, theta=0 (0x000000), tag=3 -> after 17 cycles: out_valid=1, out_cos=2097152±128, out_sin=0±128, tag=3, range_err=0.
- theta=+pi/4=1647099 -> cos=1482910±128, sin=1482910±128. theta=-pi/2=-3294199 -> cos=0±128, sin=-2097152±128, range_err=0.
- 200 random in-range angles with in_valid every cycle and incrementing tags -> 200 consecutive out_valid cycles, tags in order, each result within ±128 LSB of the real-valued cos/sin model.
- Stream with clk_en held low for 5 cycles mid-burst, plus random in_valid bubbles -> outputs frozen during the stall, no loss or duplication, each valid result still 17 enabled edges after its input.
- theta=1.8 rad=3774874 and theta=-2^22 -> out_range_err=1 on exactly those tags. Neighbouring samples are correct.
- reset pulsed for 1 cycle with 10 samples in flight -> out_valid=0 and all outputs 0 the following cycle. None of the 10 tags ever appears. A new sample after reset appears 17 cycles later.
